unidade_controle_jogo: RTL and testbench
========================================

Name: unidade_controle_jogo

Overview:
- Moore FSM control unit that sits directly upstream of the counter/comparator datapath (contador_163 + comparador_85 + registered chaves).
- Drives the datapath's zera, registra and conta inputs and consumes its igual and fim status outputs.
- Sequences one round: clear the datapath, then for each button press register chaves, compare, and either advance or end with hit, miss or timeout.
- Provides an internal rising-edge detector on the player button and an inactivity timer.

Parameters:
- TIMEOUT_CICLOS, 5000, number of clock cycles allowed in the wait state before a timeout. Legal range is 2 to 2^20.
- TW, 13, width of the timeout counter. Must satisfy 2^TW >= TIMEOUT_CICLOS.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- clr  input  1  synchronous, active-low reset (0 = reset on next rising clock edge).
- iniciar  input  1  start request; level-sampled in the initial and final states.
- jogada  input  1  player button, raw level, already synchronous to clock; edge-detected internally.
- igual  input  1  datapath comparator equality result.
- fim  input  1  datapath counter terminal count (rco).
- zera  output  1  datapath clear, one cycle, active high.
- registra  output  1  load registered chaves into the datapath, one cycle.
- conta  output  1  counter enable, one cycle.
- pronto  output  1  high while in any final state.
- acertou  output  1  high in the final-hit state.
- errou  output  1  high in the final-miss state.
- timeout  output  1  high in the final-timeout state.
- db_estado  output  4  current state code, for the hexa7seg debug display.

Behaviour:
- All outputs are Moore outputs, decoded only from the registered state. There is no input-to-output combinational path.
- Reset (clr=0 at a clock edge, from any state, including mid-round):
  - state goes to INICIAL;
  - timer goes to 0;
  - edge register jogada_d goes to 0;
  - consequently all outputs are 0 and db_estado=0.
  - Reset overrides every other input.
- Edge detect: jogada_d <= jogada every cycle. pulso = jogada & ~jogada_d.
  - A level held high produces exactly one pulso.
  - pulso is acted on only in ESPERA; pulses in any other state are discarded.
- State codes (db_estado): INICIAL=0, PREPARACAO=1, ESPERA=2, REGISTRA=3, COMPARACAO=4, PROXIMO=5, FIM_ACERTO=A, FIM_TIMEOUT=D, FIM_ERRO=E. Unused codes go to INICIAL on the next edge.
- Transitions:
  - INICIAL: iniciar=1 -> PREPARACAO; otherwise stay.
  - PREPARACAO (zera=1): -> ESPERA unconditionally.
  - ESPERA: pulso=1 -> REGISTRA. Otherwise, if timer==TIMEOUT_CICLOS-1 -> FIM_TIMEOUT. Otherwise stay. If pulso and timer expiry occur in the same cycle, pulso wins.
  - REGISTRA (registra=1): -> COMPARACAO.
  - COMPARACAO: igual=0 -> FIM_ERRO; igual=1 and fim=1 -> FIM_ACERTO; igual=1 and fim=0 -> PROXIMO.
  - PROXIMO (conta=1): -> ESPERA.
  - FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: pronto=1 plus the matching flag; iniciar=1 -> PREPARACAO; otherwise hold.
- Timer:
  - increments by 1 each cycle spent in ESPERA;
  - is cleared to 0 in every other state;
  - therefore restarts on every entry to ESPERA;
  - never wraps, because expiry leaves ESPERA.
- Latency:
  - iniciar to zera: 1 cycle.
  - jogada rising edge (sampled in ESPERA) to registra: 1 cycle.
  - registra to comparison decision: 1 cycle. The datapath must present igual in the COMPARACAO cycle.
- Each of zera, registra and conta is high for exactly one cycle per state visit. No two of them are ever high simultaneously.
- Timeout fires exactly TIMEOUT_CICLOS cycles after entry to ESPERA when there is no jogada edge.

Test Plan:
- Reset: hold clr=0 for 2 cycles with iniciar=1 and jogada=1 -> all outputs 0 and db_estado=0. Release clr -> PREPARACAO on the next edge.
- Full hit round with TIMEOUT_CICLOS=20 and a 16-entry datapath model: iniciar pulse, then 16 jogada pulses with igual=1 and fim=1 on the 16th -> 1 zera, 16 registra, 15 conta; final state A; pronto=1, acertou=1.
- Miss: on the 3rd jogada drive igual=0 -> FIM_ERRO (E); errou=1; conta was pulsed exactly 2 times.
- Timeout with TIMEOUT_CICLOS=20: no jogada after PREPARACAO -> FIM_TIMEOUT exactly 20 cycles after entering ESPERA; timeout=1.
- Edge/priority: hold jogada high for 10 cycles -> only one registra. A jogada edge on the cycle timer=19 -> REGISTRA, not timeout. A jogada edge in INICIAL -> ignored.
- Restart and mid-round reset: iniciar in FIM_ERRO -> PREPARACAO with zera=1 and all flags clear. clr=0 during COMPARACAO -> INICIAL on the next edge.

Source files
------------

// File: rtl/unidade_controle_jogo.sv
// Game-round control unit: sequences clear/register/compare/advance on the
// counter+comparator datapath, with button edge detection and inactivity timeout.
module unidade_controle_jogo #(
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned TW             = 13
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zera,
  output logic       registra,
  output logic       conta,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h3,
    COMPARACAO  = 4'h4,
    PROXIMO     = 4'h5,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  localparam logic [TW-1:0] TIMER_FIM = TW'(TIMEOUT_CICLOS - 1);

  estado_t       r_estado;
  estado_t       w_prox;
  logic          r_jogada_d;
  logic [TW-1:0] r_timer;
  logic          w_pulso;
  logic          w_zera;
  logic          w_registra;
  logic          w_conta;
  logic          w_pronto;
  logic          w_acertou;
  logic          w_errou;
  logic          w_timeout;

  assign w_pulso = jogada & ~r_jogada_d;

  // Next state, then Moore outputs decoded from it so they register in step with the state.
  always_comb begin
    w_prox     = r_estado;
    w_zera     = 1'b0;
    w_registra = 1'b0;
    w_conta    = 1'b0;
    w_pronto   = 1'b0;
    w_acertou  = 1'b0;
    w_errou    = 1'b0;
    w_timeout  = 1'b0;

    case (r_estado)
      INICIAL:     if (iniciar) w_prox = PREPARACAO;
      PREPARACAO:  w_prox = ESPERA;
      ESPERA: begin
        if (w_pulso)                  w_prox = REGISTRA;
        else if (r_timer == TIMER_FIM) w_prox = FIM_TIMEOUT;
      end
      REGISTRA:    w_prox = COMPARACAO;
      COMPARACAO: begin
        if (!igual)   w_prox = FIM_ERRO;
        else if (fim) w_prox = FIM_ACERTO;
        else          w_prox = PROXIMO;
      end
      PROXIMO:     w_prox = ESPERA;
      FIM_ACERTO,
      FIM_TIMEOUT,
      FIM_ERRO:    if (iniciar) w_prox = PREPARACAO;
      default:     w_prox = INICIAL;
    endcase

    case (w_prox)
      PREPARACAO:  w_zera     = 1'b1;
      REGISTRA:    w_registra = 1'b1;
      PROXIMO:     w_conta    = 1'b1;
      FIM_ACERTO: begin
        w_pronto  = 1'b1;
        w_acertou = 1'b1;
      end
      FIM_TIMEOUT: begin
        w_pronto  = 1'b1;
        w_timeout = 1'b1;
      end
      FIM_ERRO: begin
        w_pronto = 1'b1;
        w_errou  = 1'b1;
      end
      default: ;
    endcase
  end

  // State, edge register, inactivity timer and registered outputs.
  always_ff @(posedge clock) begin
    if (!clr) begin
      r_estado   <= INICIAL;
      r_jogada_d <= 1'b0;
      r_timer    <= '0;
      zera       <= 1'b0;
      registra   <= 1'b0;
      conta      <= 1'b0;
      pronto     <= 1'b0;
      acertou    <= 1'b0;
      errou      <= 1'b0;
      timeout    <= 1'b0;
      db_estado  <= 4'h0;
    end else begin
      r_estado   <= w_prox;
      r_jogada_d <= jogada;
      r_timer    <= (r_estado == ESPERA) ? r_timer + TW'(1) : '0;
      zera       <= w_zera;
      registra   <= w_registra;
      conta      <= w_conta;
      pronto     <= w_pronto;
      acertou    <= w_acertou;
      errou      <= w_errou;
      timeout    <= w_timeout;
      db_estado  <= w_prox;
    end
  end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: directed reset/timeout/priority steps plus
// randomized rounds against a 16-entry datapath model and round-outcome predictions.
module tb_unidade_controle_jogo;

  localparam int unsigned T_OUT = 20;

  logic       clock = 1'b0;
  logic       clr, iniciar, jogada, igual, fim;
  logic       zera, registra, conta, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  logic [3:0] mem [16];
  logic [3:0] chaves;
  logic [3:0] dp_reg;
  logic [3:0] dp_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_z = 0, n_r = 0, n_c = 0;

  always #5 clock = ~clock;

  unidade_controle_jogo #(.TIMEOUT_CICLOS(T_OUT), .TW(5)) dut (
    .clock(clock), .clr(clr), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fim(fim), .zera(zera), .registra(registra),
    .conta(conta), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .db_estado(db_estado)
  );

  // Datapath model: counter with clear/enable, registered keys, comparator.
  always_ff @(posedge clock) begin
    if (zera) dp_cnt <= 4'd0;
    else if (conta) dp_cnt <= dp_cnt + 4'd1;
    if (registra) dp_reg <= chaves;
  end
  assign igual = (dp_reg == mem[dp_cnt]);
  assign fim   = (dp_cnt == 4'd15);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters and one-hot check on the datapath controls.
  always @(negedge clock) begin
    if (zera === 1'b1) n_z++;
    if (registra === 1'b1) n_r++;
    if (conta === 1'b1) n_c++;
    if (clr === 1'b1)
      chk("ctl_exclusive", 32'($countones({zera, registra, conta}) <= 1), 32'd1);
  end

  task automatic wait_state(input logic [3:0] code, input int budget);
    int t = 0;
    while (db_estado !== code && t < budget) begin
      @(negedge clock);
      t++;
    end
    chk("wait_state", 32'(db_estado), 32'(code));
  endtask

  task automatic press(input logic [3:0] key, input int hold);
    wait_state(4'h2, 60);
    repeat ($urandom_range(0, 4)) @(negedge clock);
    chaves = key;
    jogada = 1'b1;
    @(negedge clock);
    chk("registra_latency", 32'({registra, db_estado}), 32'h13);
    repeat (hold) @(negedge clock);
    jogada = 1'b0;
    @(negedge clock);
  endtask

  task automatic start_round();
    iniciar = 1'b1;
    @(negedge clock);
    chk("start_zera", 32'({zera, pronto, acertou, errou, timeout, db_estado}), 32'h101);
    iniciar = 1'b0;
  endtask

  // mode 0: all 16 correct; 1: miss on press k; 2: k correct presses then idle.
  task automatic run_round(input int mode, input int k);
    int z0, r0, c0, presses, exp_r, exp_c;
    logic [3:0] exp_code, exp_flags, key;
    z0 = n_z; r0 = n_r; c0 = n_c;
    case (mode)
      0: begin presses = 16; exp_r = 16;    exp_c = 15;    exp_code = 4'hA; exp_flags = 4'b1100; end
      1: begin presses = k;  exp_r = k;     exp_c = k - 1; exp_code = 4'hE; exp_flags = 4'b1010; end
      default: begin presses = k; exp_r = k; exp_c = k;    exp_code = 4'hD; exp_flags = 4'b1001; end
    endcase
    start_round();
    for (int i = 0; i < presses; i++) begin
      key = mem[i];
      if (mode == 1 && i == k - 1) key = mem[i] ^ 4'($urandom_range(1, 15));
      press(key, $urandom_range(0, 3));
    end
    wait_state(exp_code, 60);
    chk("round_flags", 32'({pronto, acertou, errou, timeout}), 32'(exp_flags));
    chk("round_zera", 32'(n_z - z0), 32'd1);
    chk("round_registra", 32'(n_r - r0), 32'(exp_r));
    chk("round_conta", 32'(n_c - c0), 32'(exp_c));
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
    chaves = 4'd0; iniciar = 1'b1; jogada = 1'b1; clr = 1'b0;

    // Reset dominates iniciar/jogada
    repeat (2) @(negedge clock);
    chk("reset_outputs", 32'({zera, registra, conta, pronto, acertou, errou, timeout, db_estado}), 32'h0);
    clr = 1'b1;
    @(negedge clock);
    chk("release_prep", 32'({zera, db_estado}), 32'h11);
    clr = 1'b0; iniciar = 1'b0; jogada = 1'b0;
    @(negedge clock);
    chk("reset_again", 32'(db_estado), 32'h0);
    clr = 1'b1;

    // Button edges in INICIAL are ignored
    for (int i = 0; i < 4; i++) begin
      jogada = i[0] ? 1'b0 : 1'b1;
      @(negedge clock);
      chk("inicial_ignore", 32'({registra, db_estado}), 32'h0);
    end
    jogada = 1'b0;
    @(negedge clock);

    // Timeout exactly T_OUT cycles after entering ESPERA
    start_round();
    for (int i = 0; i < int'(T_OUT); i++) begin
      @(negedge clock);
      chk("espera_hold", 32'(db_estado), 32'h2);
    end
    @(negedge clock);
    chk("timeout_exact", 32'({pronto, acertou, errou, timeout, db_estado}), 32'h9D);

    // Edge on the last ESPERA cycle beats expiry; held level gives one registra
    start_round();
    repeat (int'(T_OUT) - 1) @(negedge clock);
    @(negedge clock);
    chk("prio_last_cycle", 32'(db_estado), 32'h2);
    r0 = n_r;
    chaves = mem[0];
    jogada = 1'b1;
    @(negedge clock);
    chk("prio_registra", 32'(db_estado), 32'h3);
    repeat (9) @(negedge clock);
    chk("held_one_registra", 32'(n_r - r0), 32'd1);
    chk("held_back_espera", 32'(db_estado), 32'h2);
    jogada = 1'b0;
    press(mem[1] ^ 4'h5, 0);
    wait_state(4'hE, 20);
    chk("miss_flags", 32'({pronto, acertou, errou, timeout}), 32'hA);

    // Restart from FIM_ERRO clears flags
    start_round();

    // Reset during COMPARACAO
    wait_state(4'h2, 10);
    chaves = mem[0];
    jogada = 1'b1;
    @(negedge clock);
    jogada = 1'b0;
    @(negedge clock);
    chk("mid_in_comp", 32'(db_estado), 32'h4);
    clr = 1'b0;
    @(negedge clock);
    chk("mid_reset", 32'({zera, registra, conta, pronto, acertou, errou, timeout, db_estado}), 32'h0);
    clr = 1'b1;
    @(negedge clock);

    // Directed full hit, miss on 3rd press, then randomized rounds
    run_round(0, 0);
    run_round(1, 3);
    for (int n = 0; n < 12; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      if (mode == 1) run_round(1, $urandom_range(1, 16));
      else if (mode == 2) run_round(2, $urandom_range(0, 15));
      else run_round(0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
